// File: rtl/axis_tap_stream_arbiter.sv
// Round-robin arbiter that merges NUM_SRC AXI tap streams onto one AXI-Stream output,
// prefixing each packet with a header beat {source id, sequence number}.
module axis_tap_stream_arbiter #(
  parameter int NUM_SRC           = 5,
  parameter int DATA_WIDTH        = 128,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter int MAX_BEATS         = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  input  logic                          m_tready,
  output logic                          busy,
  output logic [STREAM_TYPE_WIDTH-1:0]  cur_src,
  output logic [15:0]                   pkt_count
);

  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                       state, state_nxt;
  logic [STREAM_TYPE_WIDTH-1:0] cur_src_nxt;
  logic [STREAM_TYPE_WIDTH-1:0] winner;
  logic                         found;
  logic [15:0]                  seq;
  logic [BW-1:0]                beat_cnt;
  logic                         tap_valid, tap_more;
  logic [DATA_WIDTH-1:0]        tap_data;
  logic                         beat_last;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    int idx;
    idx    = 0;
    winner = cur_src;
    found  = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(cur_src) + k) % NUM_SRC;
      if (!found && src_valid[idx]) begin
        found  = 1'b1;
        winner = STREAM_TYPE_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    tap_valid = 1'b0;
    tap_more  = 1'b0;
    tap_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_src == STREAM_TYPE_WIDTH'(i)) begin
        tap_valid = src_valid[i];
        tap_more  = src_in_progress[i];
        tap_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign beat_last = (beat_cnt == BW'(MAX_BEATS - 1));

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cur_src_nxt = cur_src;
    src_ready   = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    case (state)
      IDLE: begin
        if (enable && found) begin
          cur_src_nxt = winner;
          state_nxt   = HEADER;
        end
      end
      HEADER: begin
        m_tvalid                                  = 1'b1;
        m_tdata[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = cur_src;
        m_tdata[15:0]                             = seq;
        if (m_tready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (cur_src == STREAM_TYPE_WIDTH'(i)) src_ready[i] = m_tready;
        end
        m_tvalid = tap_valid;
        m_tdata  = tap_data;
        m_tlast  = tap_valid && (!tap_more || beat_last);
        if (tap_valid && m_tready && m_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_src   <= STREAM_TYPE_WIDTH'(NUM_SRC - 1);
      seq       <= '0;
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else begin
      state   <= state_nxt;
      cur_src <= cur_src_nxt;
      if (state == HEADER && m_tready) begin
        seq      <= seq + 16'd1;
        beat_cnt <= '0;
      end
      if (state == PAYLOAD && tap_valid && m_tready) begin
        beat_cnt <= beat_cnt + BW'(1);
        if (m_tlast) pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_tap_stream_arbiter.sv
// Randomised and directed bench for axis_tap_stream_arbiter; a packet-level scoreboard
// predicts headers, payload order, tlast placement and the ready pattern.
module tb_axis_tap_stream_arbiter;

  localparam int N   = 5;
  localparam int DW  = 32;
  localparam int STW = 3;
  localparam int MB  = 4;

  logic              clk = 1'b0;
  logic              reset, enable, m_tready;
  logic [N-1:0]      src_valid, src_in_progress, src_ready;
  logic [N*DW-1:0]   src_data;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, busy;
  logic [STW-1:0]    cur_src;
  logic [15:0]       pkt_count;

  axis_tap_stream_arbiter #(
    .NUM_SRC(N), .DATA_WIDTH(DW), .STREAM_TYPE_WIDTH(STW), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .src_valid(src_valid), .src_in_progress(src_in_progress), .src_data(src_data),
    .src_ready(src_ready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .cur_src(cur_src), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Tap-side beat queues (what the taps still have to send) and scoreboard copies.
  logic [DW:0] tq [N][$];
  logic [DW:0] eq [N][$];
  logic [N-1:0] pop_tap;
  int gap_pct;

  // Scoreboard state
  bit          in_pay, hdr_latched, prev_idle, prev_en;
  logic [N-1:0] prev_valid;
  int          g, last_id, exp_id, nbeats;
  logic [15:0] model_seq, model_pkt;
  int          hdr_log[$];
  int          seq_log[$];

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_msg(input int tap, input int len);
    logic [DW:0] w;
    for (int b = 0; b < len; b++) begin
      w = {(b == len - 1), DW'($urandom())};
      tq[tap].push_back(w);
      eq[tap].push_back(w);
    end
  endtask

  // Tap driver: pops a beat after each handshake and presents the next one.
  initial begin
    logic [DW:0] w;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) tq[i].delete();
        else if (pop_tap[i] && tq[i].size() > 0) void'(tq[i].pop_front());
        if (!reset && tq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
          w = tq[i][0];
          src_valid[i]             = 1'b1;
          src_in_progress[i]       = !w[DW];
          src_data[i*DW +: DW]     = w[DW-1:0];
        end else begin
          src_valid[i]             = 1'b0;
          src_in_progress[i]       = 1'b0;
          src_data[i*DW +: DW]     = '0;
        end
      end
    end
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  initial begin
    logic [DW-1:0] hdr;
    logic [N-1:0]  exp_ready;
    logic [DW:0]   b;
    bit            exp_last, idle_now;
    forever begin
      @(negedge clk);
      pop_tap = '0;
      if (!reset) begin
        pop_tap  = src_valid & src_ready;
        idle_now = !in_pay && !m_tvalid;
        if (!in_pay) begin
          total++;
          if (src_ready !== '0) begin
            bad++; $display("FAIL ready_outside_payload: got %b, required 0", src_ready);
          end
          if (!hdr_latched && m_tvalid) begin
            total++;
            if (!(prev_idle && prev_en && |prev_valid)) begin
              bad++; $display("FAIL spurious_header: header appeared without a granted request");
            end
            exp_id      = rr_pick(last_id, prev_valid);
            hdr_latched = 1'b1;
          end else if (!hdr_latched && prev_idle && prev_en && |prev_valid) begin
            total++; bad++;
            $display("FAIL missed_grant: no header one cycle after request, valid=%b", prev_valid);
          end
          if (hdr_latched) begin
            hdr = '0;
            hdr[DW-1 -: STW] = exp_id[STW-1:0];
            hdr[15:0]        = model_seq;
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== hdr || m_tlast !== 1'b0) begin
              bad++;
              $display("FAIL header: got v=%b d=%h l=%b, required v=1 d=%h l=0",
                       m_tvalid, m_tdata, m_tlast, hdr);
            end
            if (m_tready) begin
              hdr_log.push_back(exp_id);
              seq_log.push_back(int'(model_seq));
              model_seq   = model_seq + 16'd1;
              g           = exp_id;
              last_id     = exp_id;
              nbeats      = 0;
              in_pay      = 1'b1;
              hdr_latched = 1'b0;
            end
          end
        end else begin
          exp_ready = '0;
          exp_ready[g] = m_tready;
          total++;
          if (src_ready !== exp_ready || m_tvalid !== src_valid[g]) begin
            bad++;
            $display("FAIL payload_ctrl: got ready=%b v=%b, required ready=%b v=%b",
                     src_ready, m_tvalid, exp_ready, src_valid[g]);
          end
          if (m_tvalid && m_tready) begin
            total++;
            if (eq[g].size() == 0) begin
              bad++; $display("FAIL extra_beat: tap %0d got d=%h, required no beat", g, m_tdata);
            end else begin
              b        = eq[g].pop_front();
              exp_last = b[DW] || (nbeats == MB - 1);
              if (m_tdata !== b[DW-1:0] || m_tlast !== exp_last) begin
                bad++;
                $display("FAIL beat: tap %0d got d=%h l=%b, required d=%h l=%b",
                         g, m_tdata, m_tlast, b[DW-1:0], exp_last);
              end
              nbeats++;
              if (exp_last) begin
                model_pkt = model_pkt + 16'd1;
                in_pay    = 1'b0;
              end
            end
          end
        end
        prev_idle  = idle_now;
        prev_valid = src_valid;
        prev_en    = enable;
      end
    end
  end

  task automatic assert_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      tq[i].delete();
      eq[i].delete();
    end
    src_valid = '0; src_in_progress = '0; src_data = '0;
    in_pay = 0; hdr_latched = 0; prev_idle = 0; prev_en = 0; prev_valid = '0;
    last_id = N - 1; model_seq = '0; model_pkt = '0; nbeats = 0;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) step();
    reset = 1'b0;
    step();
    hdr_log.delete();
    seq_log.delete();
  endtask

  task automatic drain(input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      step(); n++;
      done = !in_pay && !hdr_latched;
      for (int i = 0; i < N; i++) if (eq[i].size() != 0 || tq[i].size() != 0) done = 0;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL drain_timeout: beats still pending after %0d cycles, required 0", budget);
    end
    step(); step();
  endtask

  task automatic check_outputs_idle(input string tag);
    total++;
    if (m_tvalid !== 0 || m_tlast !== 0 || m_tdata !== '0 || src_ready !== '0 ||
        busy !== 0 || cur_src !== STW'(N - 1) || pkt_count !== 16'd0) begin
      bad++;
      $display("FAIL %s: got v=%b l=%b d=%h rdy=%b busy=%b cur=%0d pkt=%0d, required zeros cur=%0d",
               tag, m_tvalid, m_tlast, m_tdata, src_ready, busy, cur_src, pkt_count, N - 1);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    check_outputs_idle("reset_state");
    repeat (2) step();
    reset = 1'b0;
    step();
    check_outputs_idle("after_release");
    hdr_log.delete(); seq_log.delete();
  endtask

  task automatic test_single();
    push_msg(2, 3);
    drain(100);
    total++;
    if (pkt_count !== 16'd1 || hdr_log.size() != 1 || hdr_log[0] != 2 || seq_log[0] != 0) begin
      bad++; $display("FAIL single: got pkt=%0d hdrs=%p seqs=%p, required pkt=1 hdrs='{2} seqs='{0}",
                      pkt_count, hdr_log, seq_log);
    end
    total++;
    if (cur_src !== 3'd2) begin
      bad++; $display("FAIL single_cur_src: got %0d, required 2", cur_src);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    push_msg(3, 1); push_msg(1, 1); push_msg(0, 1);
    drain(100);
    total++;
    if (hdr_log.size() != 3 || hdr_log[0] != 0 || hdr_log[1] != 1 || hdr_log[2] != 3 ||
        seq_log[0] != 0 || seq_log[1] != 1 || seq_log[2] != 2) begin
      bad++; $display("FAIL round_robin: got hdrs=%p seqs=%p, required '{0,1,3} '{0,1,2}",
                      hdr_log, seq_log);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] snap;
    int n;
    hdr_log.delete(); seq_log.delete();
    m_tready = 1'b0;
    push_msg(3, 3);
    n = 0;
    while (!hdr_latched && n < 20) begin step(); n++; end
    snap = m_tdata;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (m_tdata !== snap || src_ready !== '0 || m_tvalid !== 1'b1) begin
        bad++; $display("FAIL hdr_hold: got d=%h rdy=%b v=%b, required d=%h rdy=0 v=1",
                        m_tdata, src_ready, m_tvalid, snap);
      end
    end
    m_tready = 1'b1;
    n = 0;
    while (!(in_pay && nbeats == 1) && n < 20) begin step(); n++; end
    m_tready = 1'b0;
    step();
    snap = m_tdata;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (m_tdata !== snap || src_ready !== '0 || nbeats != 1) begin
        bad++; $display("FAIL beat_hold: got d=%h rdy=%b beats=%0d, required d=%h rdy=0 beats=1",
                        m_tdata, src_ready, nbeats, snap);
      end
    end
    m_tready = 1'b1;
    drain(100);
    total++;
    if (hdr_log.size() != 1 || hdr_log[0] != 3 || pkt_count !== model_pkt) begin
      bad++; $display("FAIL backpressure: got hdrs=%p pkt=%0d, required '{3} pkt=%0d",
                      hdr_log, pkt_count, model_pkt);
    end
  endtask

  task automatic test_split();
    logic [15:0] p0;
    hdr_log.delete(); seq_log.delete();
    p0 = pkt_count;
    push_msg(1, 6);
    drain(100);
    total++;
    if (hdr_log.size() != 2 || hdr_log[0] != 1 || hdr_log[1] != 1 ||
        seq_log[1] != ((seq_log[0] + 1) & 16'hFFFF) || pkt_count !== p0 + 16'd2) begin
      bad++; $display("FAIL split: got hdrs=%p seqs=%p pkt=%0d, required '{1,1} consecutive pkt=%0d",
                      hdr_log, seq_log, pkt_count, p0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    push_msg(2, 4);
    n = 0;
    while (!(in_pay && nbeats == 1) && n < 20) begin step(); n++; end
    assert_reset();
    #1;
    check_outputs_idle("reset_mid_packet");
    repeat (2) step();
    reset = 1'b0;
    step();
    hdr_log.delete(); seq_log.delete();
    push_msg(3, 1); push_msg(0, 1);
    drain(100);
    total++;
    if (hdr_log.size() != 2 || hdr_log[0] != 0 || seq_log[0] != 0 || hdr_log[1] != 3) begin
      bad++; $display("FAIL post_reset_order: got hdrs=%p seqs=%p, required '{0,3} first seq 0",
                      hdr_log, seq_log);
    end
  endtask

  task automatic test_enable();
    int n;
    logic [15:0] p0;
    hdr_log.delete(); seq_log.delete();
    p0 = pkt_count;
    enable = 1'b0;
    push_msg(4, 3);
    repeat (10) step();
    total++;
    if (busy !== 1'b0 || hdr_log.size() != 0 || pkt_count !== p0) begin
      bad++; $display("FAIL enable_low: got busy=%b hdrs=%0d pkt=%0d, required 0 0 %0d",
                      busy, hdr_log.size(), pkt_count, p0);
    end
    enable = 1'b1;
    n = 0;
    while (!in_pay && n < 20) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while ((in_pay || eq[4].size() != 0) && n < 50) begin step(); n++; end
    total++;
    if (pkt_count !== p0 + 16'd1 || eq[4].size() != 0 || hdr_log.size() != 1 || hdr_log[0] != 4) begin
      bad++; $display("FAIL enable_drop: got pkt=%0d left=%0d hdrs=%p, required pkt=%0d left=0 '{4}",
                      pkt_count, eq[4].size(), hdr_log, p0 + 16'd1);
    end
    step();
    force dut.seq = 16'hFFFF;
    model_seq = 16'hFFFF;
    step();
    release dut.seq;
    enable = 1'b1;
    hdr_log.delete(); seq_log.delete();
    push_msg(0, 1);
    drain(100);
    push_msg(1, 1);
    drain(100);
    total++;
    if (seq_log.size() != 2 || seq_log[0] != 16'hFFFF || seq_log[1] != 0) begin
      bad++; $display("FAIL seq_wrap: got seqs=%p, required '{65535,0}", seq_log);
    end
  endtask

  task automatic test_random();
    gap_pct = 20;
    for (int c = 0; c < 1500; c++) begin
      m_tready = ($urandom_range(3) != 0);
      enable   = ($urandom_range(7) != 0);
      if ($urandom_range(3) == 0) push_msg($urandom_range(N - 1), $urandom_range(7, 1));
      step();
    end
    enable = 1'b1; m_tready = 1'b1; gap_pct = 0;
    drain(3000);
    total++;
    if (pkt_count !== model_pkt || cur_src !== STW'(last_id)) begin
      bad++; $display("FAIL random_final: got pkt=%0d cur=%0d, required pkt=%0d cur=%0d",
                      pkt_count, cur_src, model_pkt, last_id);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; m_tready = 1'b1; gap_pct = 0;
    src_valid = '0; src_in_progress = '0; src_data = '0; pop_tap = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_split();
    test_reset_mid_packet();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
